// File: rtl/plru_victim_select_pkg.sv
// Shared types and constants for the 4-way tree-PLRU victim selector.
package plru_victim_select_pkg;

    typedef logic [2:0] plru_t;
    typedef logic [1:0] way_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } victim_state_t;

    localparam plru_t PLRU_RESET = 3'b000;

endpackage

// File: rtl/plru_next_state.sv
// Tree-PLRU update: marks the accessed way most-recently-used in its subtree.
module plru_next_state
    import plru_victim_select_pkg::*;
(
    input  plru_t tree,
    input  way_t  way,
    output plru_t tree_nxt
);

    always_comb begin
        tree_nxt    = tree;
        tree_nxt[0] = ~way[1];
        if (way[1]) begin
            tree_nxt[2] = ~way[0];
        end else begin
            tree_nxt[1] = ~way[0];
        end
    end

endmodule

// File: rtl/plru_victim_select.sv
// Per-set PLRU state with a registered request/acknowledge victim lookup.
module plru_victim_select
    import plru_victim_select_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [SET_W-1:0] req_set,
    input  logic [3:0]       req_way_valid,
    output logic             req_ready,
    output logic             victim_valid,
    output logic [1:0]       victim_way,
    input  logic             victim_ack,
    input  logic             upd_valid,
    input  logic [SET_W-1:0] upd_set,
    input  logic [1:0]       upd_way
);

    plru_t         tree_q [NUM_SETS];
    plru_t         upd_tree_nxt;
    plru_t         req_tree_c;
    way_t          victim_c;
    victim_state_t state_q, state_d;
    logic          victim_valid_d;
    logic          req_ready_d;
    way_t          victim_way_d;

    plru_next_state u_next (
        .tree     (tree_q[upd_set]),
        .way      (upd_way),
        .tree_nxt (upd_tree_nxt)
    );

    // Tree array; one update per cycle regardless of FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SETS); i++) begin
                tree_q[i] <= PLRU_RESET;
            end
        end else if (upd_valid) begin
            tree_q[upd_set] <= upd_tree_nxt;
        end
    end

    // Same-set update in the request cycle is bypassed into the decode
    always_comb begin
        req_tree_c = tree_q[req_set];
        if (upd_valid && (upd_set == req_set)) begin
            req_tree_c = upd_tree_nxt;
        end
    end

    // Lowest invalid way wins over the PLRU decode
    always_comb begin
        victim_c = req_tree_c[0] ? {1'b1, req_tree_c[2]} : {1'b0, req_tree_c[1]};
        if (!req_way_valid[0]) begin
            victim_c = 2'd0;
        end else if (!req_way_valid[1]) begin
            victim_c = 2'd1;
        end else if (!req_way_valid[2]) begin
            victim_c = 2'd2;
        end else if (!req_way_valid[3]) begin
            victim_c = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            victim_valid <= 1'b0;
            victim_way   <= 2'd0;
            req_ready    <= 1'b1;
        end else begin
            state_q      <= state_d;
            victim_valid <= victim_valid_d;
            victim_way   <= victim_way_d;
            req_ready    <= req_ready_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        victim_valid_d = victim_valid;
        victim_way_d   = victim_way;
        req_ready_d    = req_ready;
        case (state_q)
            IDLE: begin
                req_ready_d    = 1'b1;
                victim_valid_d = 1'b0;
                if (req_valid) begin
                    state_d        = RESP;
                    victim_way_d   = victim_c;
                    victim_valid_d = 1'b1;
                    req_ready_d    = 1'b0;
                end
            end
            RESP: begin
                req_ready_d    = 1'b0;
                victim_valid_d = 1'b1;
                if (victim_ack) begin
                    state_d        = IDLE;
                    victim_valid_d = 1'b0;
                    req_ready_d    = 1'b1;
                end
            end
            default: begin
                state_d        = IDLE;
                victim_valid_d = 1'b0;
                req_ready_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_plru_victim_select.sv
// Directed bench for plru_victim_select with hand-computed victims.
module tb_plru_victim_select;

    localparam int unsigned NUM_SETS = 16;
    localparam int unsigned SET_W    = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic [SET_W-1:0] req_set;
    logic [3:0]       req_way_valid;
    logic             req_ready;
    logic             victim_valid;
    logic [1:0]       victim_way;
    logic             victim_ack;
    logic             upd_valid;
    logic [SET_W-1:0] upd_set;
    logic [1:0]       upd_way;

    int total = 0;
    int bad   = 0;

    plru_victim_select #(.NUM_SETS(NUM_SETS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_set       (req_set),
        .req_way_valid (req_way_valid),
        .req_ready     (req_ready),
        .victim_valid  (victim_valid),
        .victim_way    (victim_way),
        .victim_ack    (victim_ack),
        .upd_valid     (upd_valid),
        .upd_set       (upd_set),
        .upd_way       (upd_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [SET_W-1:0] s, input logic [1:0] w);
        upd_valid = 1'b1;
        upd_set   = s;
        upd_way   = w;
        step();
        upd_valid = 1'b0;
    endtask

    // Issue a request, check the victim one cycle later (stays in RESP)
    task automatic do_req(input string tag, input logic [SET_W-1:0] s,
                          input logic [3:0] wv, input logic [1:0] exp_way);
        req_valid     = 1'b1;
        req_set       = s;
        req_way_valid = wv;
        step();
        req_valid     = 1'b0;
        upd_valid     = 1'b0;
        chk({tag, "_vld"}, 32'(victim_valid), 32'd1);
        chk({tag, "_way"}, 32'(victim_way), 32'(exp_way));
        chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
    endtask

    task automatic do_ack(input string tag);
        victim_ack = 1'b1;
        step();
        victim_ack = 1'b0;
        chk({tag, "_ackvld"}, 32'(victim_valid), 32'd0);
        chk({tag, "_ackrdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_set       = '0;
        req_way_valid = 4'hF;
        victim_ack    = 1'b0;
        upd_valid     = 1'b0;
        upd_set       = '0;
        upd_way       = '0;
        #12;
        chk("rst_vld", 32'(victim_valid), 32'd0);
        chk("rst_way", 32'(victim_way), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Basic request, hold without ack; requests during RESP are ignored
        do_req("s3", 4'd3, 4'hF, 2'd0);
        for (int i = 0; i < 3; i++) begin
            req_valid     = 1'b1;
            req_set       = 4'd1;
            req_way_valid = 4'b1110;
            step();
            chk("s3_hold_way", 32'(victim_way), 32'd0);
            chk("s3_hold_vld", 32'(victim_valid), 32'd1);
            chk("s3_hold_rdy", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        do_ack("s3");
        // Ack in IDLE is ignored
        victim_ack = 1'b1;
        step();
        victim_ack = 1'b0;
        chk("idle_ack_vld", 32'(victim_valid), 32'd0);
        chk("idle_ack_rdy", 32'(req_ready), 32'd1);

        // Set 5: ways 0,1,2,3 -> tree 000 -> victim 0; then way 0 -> tree 011 -> victim 2
        do_upd(4'd5, 2'd0);
        do_upd(4'd5, 2'd1);
        do_upd(4'd5, 2'd2);
        do_upd(4'd5, 2'd3);
        do_req("s5a", 4'd5, 4'hF, 2'd0);
        do_ack("s5a");
        do_upd(4'd5, 2'd0);
        do_req("s5b", 4'd5, 4'hF, 2'd2);
        do_ack("s5b");

        // Invalid-way priority
        do_upd(4'd1, 2'd2);
        do_req("inv1011", 4'd1, 4'b1011, 2'd2);
        do_ack("inv1011");
        do_req("inv0000", 4'd1, 4'b0000, 2'd0);
        do_ack("inv0000");
        do_req("inv0111", 4'd1, 4'b0111, 2'd3);
        do_ack("inv0111");

        // Same-cycle same-set: way 2 -> tree 100 -> victim 0
        upd_valid = 1'b1; upd_set = 4'd7; upd_way = 2'd2;
        do_req("byp7", 4'd7, 4'hF, 2'd0);
        do_ack("byp7");
        // Same-cycle same-set: way 0 -> tree 011 -> victim 2 (bypass visible)
        upd_valid = 1'b1; upd_set = 4'd8; upd_way = 2'd0;
        do_req("byp8", 4'd8, 4'hF, 2'd2);
        do_ack("byp8");
        // Different set: request sees its own stored tree
        upd_valid = 1'b1; upd_set = 4'd6; upd_way = 2'd0;
        do_req("ind12", 4'd12, 4'hF, 2'd0);
        do_ack("ind12");
        do_req("s6", 4'd6, 4'hF, 2'd2);
        do_ack("s6");

        // Update during RESP must not disturb the registered victim
        do_req("s10a", 4'd10, 4'hF, 2'd0);
        do_upd(4'd10, 2'd0);
        chk("s10_hold0", 32'(victim_way), 32'd0);
        step();
        chk("s10_hold1", 32'(victim_way), 32'd0);
        chk("s10_hold_vld", 32'(victim_valid), 32'd1);
        do_ack("s10a");
        do_req("s10b", 4'd10, 4'hF, 2'd2);
        do_ack("s10b");

        // Reset mid-RESP clears valid immediately and the tree state
        do_upd(4'd9, 2'd0);
        do_req("s9a", 4'd9, 4'hF, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", 32'(victim_valid), 32'd0);
        chk("midrst_rdy", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        do_req("s9b", 4'd9, 4'hF, 2'd0);
        do_ack("s9b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
